ioctl_sdram_writer: RTL

Receives the HPS ROM download byte stream (`ioctl_*`) and packs it into 32-bit little-endian words. Each completed word is written to SDRAM through the controller's `req`/`ack` write interface. It sits between `hps_io` and the SDRAM port in the top level, and owns game-index capture and ROM-ready signalling. It exerts back-pressure on `hps_io` through `ioctl_wait`.

---
 rtl/ioctl_sdram_writer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/ioctl_sdram_writer.sv
// ioctl_sdram_writer
//
// Packs the HPS ROM download byte stream into 32-bit little-endian words and
// writes each completed word to SDRAM through a req/ack write port. It also
// latches the game-select byte and reports when every ROM byte has been
// committed to SDRAM.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   ioctl_addr/data     byte address and data of the current download byte
//   ioctl_wr            one-cycle byte strobe
//   ioctl_download      high while a download is in progress
//   ioctl_index         download type (ROM_INDEX = ROM data, GAME_INDEX = game select)
//   ioctl_wait          back-pressure to hps_io (a complete word is queued)
//   sdram_addr/data     16-bit-word address (bit 0 = 0) and 32-bit write data
//   sdram_we, sdram_req write request, held until sdram_ack
//   sdram_ack           one-cycle accept from the SDRAM controller
//   game_index          latched game select
//   rom_ready           all ROM bytes of the last download are in SDRAM
//   overrun             sticky: a ROM byte arrived while ioctl_wait was high
module ioctl_sdram_writer #(
    parameter logic [7:0] ROM_INDEX  = 8'd0,
    parameter logic [7:0] GAME_INDEX = 8'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [22:0] sdram_addr,
    output logic [31:0] sdram_data,
    output logic        sdram_we,
    output logic        sdram_req,
    input  logic        sdram_ack,
    output logic [3:0]  game_index,
    output logic        rom_ready,
    output logic        overrun
);

    typedef enum logic {
        SLOT_IDLE,
        SLOT_BUSY
    } slot_state_t;

    typedef enum logic [1:0] {
        DL_IDLE,
        DL_LOAD,
        DL_FLUSH,
        DL_READY
    } dl_state_t;

    slot_state_t slot_q, slot_d;
    dl_state_t   dl_q, dl_d;

    logic [31:0] pack_q, pack_d;
    logic [22:0] pack_addr_q, pack_addr_d;
    logic        pack_full_q, pack_full_d;
    logic        pack_has_q, pack_has_d;
    logic [22:0] slot_addr_q, slot_addr_d;
    logic [31:0] slot_data_q, slot_data_d;
    logic        dl_prev_q, dl_prev_d;
    logic [3:0]  game_q, game_d;
    logic        overrun_q, overrun_d;

    logic        rom_wr;
    logic        game_wr;
    logic        byte_ok;
    logic        word_done;
    logic        slot_ack;
    logic        slot_free;
    logic        flush_go;
    logic        dl_rise;
    logic        dl_fall;
    logic [1:0]  lane;
    logic [22:0] word_addr;
    logic [31:0] merged;

    // Bit 24 lies beyond the 16-bit-word address range of the SDRAM port.
    logic unused_addr_msb;
    assign unused_addr_msb = ioctl_addr[24];

    always_comb begin
        slot_d      = slot_q;
        dl_d        = dl_q;
        pack_d      = pack_q;
        pack_addr_d = pack_addr_q;
        pack_full_d = pack_full_q;
        pack_has_d  = pack_has_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        dl_prev_d   = ioctl_download;
        game_d      = game_q;
        overrun_d   = overrun_q;

        rom_wr    = ioctl_wr && (ioctl_index == ROM_INDEX);
        game_wr   = ioctl_wr && (ioctl_index == GAME_INDEX);
        byte_ok   = rom_wr && !pack_full_q;
        lane      = ioctl_addr[1:0];
        word_addr = {ioctl_addr[23:2], 1'b0};
        merged    = pack_q;
        merged[{lane, 3'b000} +: 8] = ioctl_data;
        word_done = byte_ok && (lane == 2'd3);
        slot_ack  = (slot_q == SLOT_BUSY) && sdram_ack;
        // The slot can take a new word either when empty or on the edge
        // at which its current word is accepted.
        slot_free = (slot_q == SLOT_IDLE) || slot_ack;
        flush_go  = (dl_q == DL_FLUSH) && pack_has_q && !pack_full_q;
        dl_rise   = ioctl_download && !dl_prev_q && (ioctl_index == ROM_INDEX);
        dl_fall   = !ioctl_download && dl_prev_q;

        if (game_wr) begin
            game_d = ioctl_data[3:0];
        end

        if (rom_wr && pack_full_q) begin
            overrun_d = 1'b1;
        end

        if (slot_ack) begin
            slot_d = SLOT_IDLE;
        end

        if (slot_ack && pack_full_q) begin
            // Queued word follows straight on; req stays high.
            slot_d      = SLOT_BUSY;
            slot_addr_d = pack_addr_q;
            slot_data_d = pack_q;
            pack_d      = '0;
            pack_full_d = 1'b0;
            pack_has_d  = 1'b0;
        end else if (word_done) begin
            if (slot_free) begin
                slot_d      = SLOT_BUSY;
                slot_addr_d = word_addr;
                slot_data_d = merged;
                pack_d      = '0;
                pack_has_d  = 1'b0;
            end else begin
                pack_d      = merged;
                pack_addr_d = word_addr;
                pack_full_d = 1'b1;
                pack_has_d  = 1'b1;
            end
        end else if (byte_ok) begin
            pack_d      = merged;
            pack_addr_d = word_addr;
            pack_has_d  = 1'b1;
        end else if (flush_go && slot_free) begin
            // Trailing partial word: unwritten lanes are already zero.
            slot_d      = SLOT_BUSY;
            slot_addr_d = pack_addr_q;
            slot_data_d = pack_q;
            pack_d      = '0;
            pack_has_d  = 1'b0;
        end

        if (dl_rise) begin
            dl_d = DL_LOAD;
        end else begin
            case (dl_q)
                DL_LOAD: begin
                    if (dl_fall) begin
                        dl_d = DL_FLUSH;
                    end
                end
                DL_FLUSH: begin
                    if (!pack_has_q && (slot_q == SLOT_IDLE)) begin
                        dl_d = DL_READY;
                    end
                end
                default: begin
                    dl_d = dl_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q      <= SLOT_IDLE;
            dl_q        <= DL_IDLE;
            pack_q      <= '0;
            pack_addr_q <= '0;
            pack_full_q <= 1'b0;
            pack_has_q  <= 1'b0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            dl_prev_q   <= 1'b0;
            game_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            dl_q        <= dl_d;
            pack_q      <= pack_d;
            pack_addr_q <= pack_addr_d;
            pack_full_q <= pack_full_d;
            pack_has_q  <= pack_has_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            dl_prev_q   <= dl_prev_d;
            game_q      <= game_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sdram_req  = (slot_q == SLOT_BUSY);
    assign sdram_we   = (slot_q == SLOT_BUSY);
    assign sdram_addr = slot_addr_q;
    assign sdram_data = slot_data_q;
    assign ioctl_wait = pack_full_q;
    assign rom_ready  = (dl_q == DL_READY);
    assign game_index = game_q;
    assign overrun    = overrun_q;

endmodule
